// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared core defines and fetch-path types
package fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - plain modular adder shared across the core
module Adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    // Carry-out is dropped so results wrap modulo 2^W.
    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous fetch FIFO with clear and head output
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointers and occupancy; clear wins over any same-cycle push or pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage array; entries need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            Clk,
    input  logic            Rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issued_pc_q, issued_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] pc_plus4;

    logic            push;
    logic            pop;
    logic            clear;
    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic [CW:0]     avail;
    fetch_entry_t    push_data;
    fetch_entry_t    head;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    Adder #(.W(XLEN)) u_pc_inc (
        .a_i   (pc_q),
        .b_i   (XLEN'(4)),
        .sum_o (pc_plus4)
    );

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    // Issue/credit decisions and next-state for pc and the in-flight slot.
    always_comb begin
        if_valid    = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;
        clear       = 1'b0;
        imem_req    = 1'b0;
        pc_d        = pc_q;
        inflight_d  = 1'b0;
        issued_pc_d = issued_pc_q;

        // Issue only while queue slots not already claimed remain:
        // count + inflight < DEPTH + pop, i.e. credit > 0.
        used  = {1'b0, count} + (CW + 1)'(inflight_q);
        avail = DEPTH_W + (CW + 1)'(pop);

        if (Rst_n && !redirect) begin
            if_valid = (count != '0);
            pop      = if_valid && if_ready;
            avail    = DEPTH_W + (CW + 1)'(pop);
            imem_req = (used < avail);
            push     = inflight_q;
            if (imem_req) begin
                pc_d        = pc_plus4;
                issued_pc_d = pc_q;
            end
            inflight_d = imem_req;
        end else if (Rst_n && redirect) begin
            clear = 1'b1;
            pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    assign push_data = '{pc: issued_pc_q, instr: imem_rdata};

    assign imem_addr = Rst_n ? pc_q : RESET_PC;
    assign if_pc     = Rst_n ? head.pc : '0;
    assign if_instr  = Rst_n ? head.instr : '0;

    // PC, in-flight flag and the address tagged onto the pending response.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            issued_pc_q <= '0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            issued_pc_q <= issued_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC1  = 64'h0;
    localparam logic [63:0] RPC2  = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_ready = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] imem_rdata2 = 32'hDEAD_BEEF;

    logic        imem_req, imem_req2;
    logic [63:0] imem_addr, imem_addr2;
    logic        if_valid, if_valid2;
    logic [63:0] if_pc, if_pc2;
    logic [31:0] if_instr, if_instr2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
        .Clk(clk), .Rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid2), .if_ready(if_ready),
        .if_pc(if_pc2), .if_instr(if_instr2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: queue of delivered PCs plus one pending request.
    logic [63:0] mq[$];
    logic [63:0] m_pc = RPC1;
    bit          m_infl = 1'b0;
    logic [63:0] m_infl_pc = '0;

    // Transfers observed at the DUT outputs, for literal sequence checks.
    logic [63:0] log1[$];
    logic [63:0] log2[$];

    // Memory side: what each DUT requested in the previous cycle.
    bit          mem_req, mem_req2;
    logic [63:0] mem_addr, mem_addr2;

    // Per-cycle snapshot of DUT outputs for literal checks.
    bit          s_valid, s_req;
    logic [63:0] s_addr, s_if_pc;
    int          step_idx = 0;
    int          first_valid = -1;

    function automatic logic [31:0] tag(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [63:0] at(input logic [63:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, step_idx);
        end
    endtask

    task automatic step();
        bit          ev, ep, er;
        int          credit;
        logic [63:0] ea;
        @(negedge clk);
        ev     = rst_n && !redirect && (mq.size() > 0);
        ep     = ev && if_ready;
        credit = DEPTH - mq.size() - int'(m_infl) + int'(ep);
        er     = rst_n && !redirect && (credit > 0);
        ea     = rst_n ? m_pc : RPC1;
        chk("imem_req", 64'(imem_req), 64'(er));
        chk("imem_addr", imem_addr, ea);
        chk("if_valid", 64'(if_valid), 64'(ev));
        if (!rst_n) begin
            chk("rst_if_pc", if_pc, 64'h0);
            chk("rst_if_instr", 64'(if_instr), 64'h0);
            chk("rst_imem_addr2", imem_addr2, RPC2);
            chk("rst_if_valid2", 64'(if_valid2), 64'h0);
        end else if (ev) begin
            chk("if_pc", if_pc, mq[0]);
            chk("if_instr", 64'(if_instr), 64'(tag(mq[0])));
        end
        s_valid = if_valid; s_req = imem_req; s_addr = imem_addr; s_if_pc = if_pc;
        if (if_valid && if_ready) log1.push_back(if_pc);
        if (if_valid2 && if_ready) log2.push_back(if_pc2);
        if (if_valid && first_valid < 0) first_valid = step_idx;
        mem_req = imem_req;   mem_addr = imem_addr;
        mem_req2 = imem_req2; mem_addr2 = imem_addr2;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete(); m_pc = RPC1; m_infl = 1'b0;
        end else if (redirect) begin
            mq.delete(); m_pc = {redirect_pc[63:2], 2'b00}; m_infl = 1'b0;
        end else begin
            if (ep) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (er) begin
                m_infl_pc = m_pc;
                m_pc = m_pc + 64'd4;
            end
            m_infl = er;
        end
        #1;
        imem_rdata  = mem_req  ? tag(mem_addr)  : 32'hDEAD_BEEF;
        imem_rdata2 = mem_req2 ? tag(mem_addr2) : 32'hDEAD_BEEF;
        step_idx++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset with a redirect pending: redirect must be ignored.
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 64'h500;
        steps(2);
        redirect = 1'b0;

        // Streaming from reset with decode always ready.
        rst_n = 1'b1; if_ready = 1'b1;
        log1.delete(); log2.delete(); step_idx = 0; first_valid = -1;
        steps(7);
        chk("first_valid_cycle", 64'(first_valid), 64'd2);
        chk("stream_pc0", at(log1, 0), 64'h0);
        chk("stream_pc1", at(log1, 1), 64'h4);
        chk("stream_pc2", at(log1, 2), 64'h8);
        chk("stream_pc3", at(log1, 3), 64'hC);
        chk("stream_count", 64'(log1.size()), 64'd5);
        chk("wrap_pc0", at(log2, 0), 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_pc1", at(log2, 1), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc2", at(log2, 2), 64'h0);
        chk("wrap_pc3", at(log2, 3), 64'h4);

        // One-cycle reset mid-stream, then backpressure right at first valid.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(s_valid), 64'h0);
        chk("post_rst_addr", s_addr, RPC1);
        chk("post_rst_req", 64'(s_req), 64'h1);
        step();
        if_ready = 1'b0;
        log1.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_if_pc", s_if_pc, 64'h0);
        end
        chk("stall_req_low", 64'(s_req), 64'h0);
        chk("stall_no_xfer", 64'(log1.size()), 64'd0);
        if_ready = 1'b1;
        steps(4);
        chk("release_pc0", at(log1, 0), 64'h0);
        chk("release_pc1", at(log1, 1), 64'h4);
        chk("release_pc2", at(log1, 2), 64'h8);

        // Redirect while entries are queued and a request is in flight.
        redirect = 1'b1; redirect_pc = 64'h103;
        log1.delete();
        step();
        chk("redir_valid", 64'(s_valid), 64'h0);
        chk("redir_req", 64'(s_req), 64'h0);
        redirect = 1'b0;
        step();
        chk("redir_next_addr", s_addr, 64'h100);
        chk("redir_next_req", 64'(s_req), 64'h1);
        steps(4);
        chk("redir_pc0", at(log1, 0), 64'h100);
        chk("redir_pc1", at(log1, 1), 64'h104);

        // Back-to-back redirects: only the last target stream survives.
        redirect = 1'b1; redirect_pc = 64'h200;
        log1.delete();
        step();
        redirect_pc = 64'h300;
        step();
        redirect = 1'b0;
        steps(5);
        chk("b2b_pc0", at(log1, 0), 64'h300);
        chk("b2b_pc1", at(log1, 1), 64'h304);
        chk("b2b_pc2", at(log1, 2), 64'h308);

        // Random backpressure soak checked by the model alone.
        for (int i = 0; i < 200; i++) begin
            if_ready = 1'($urandom_range(0, 1));
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = {32'h0, $urandom};
            rst_n = ($urandom_range(0, 40) != 0);
            step();
        end
        rst_n = 1'b1; redirect = 1'b0;
        steps(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
